// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU in EX.
// Define DIV_REM_CACHE_EN to reuse the last computed result for a repeated operand pair.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StartE,
  input  logic [4:0]  ALUControlE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        FlushE,
  output logic        StallE,
  output logic        DoneE,
  output logic [31:0] DivResultE
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [32:0] rem;
  logic [31:0] quo, dvs;
  logic        s_rem, s_qneg, s_rneg;

  logic        is_div_op, op_signed, op_rem, accept, fast, last_iter;
  logic        a_neg, b_neg, div_zero, ovf, cache_hit;
  logic [31:0] a_mag, b_mag, fast_result;
  logic [33:0] shifted, trial;
  logic [32:0] rem_step;
  logic [31:0] quo_step, q_fix, r_fix, calc_result;

  assign is_div_op = (ALUControlE == 5'b10001) || (ALUControlE == 5'b10101) ||
                     (ALUControlE == 5'b11001) || (ALUControlE == 5'b11101);
  assign op_signed = ~ALUControlE[2];
  assign op_rem    = ALUControlE[3];
  assign StallE    = StartE & is_div_op & ~DoneE;
  assign accept    = (state == IDLE) & StartE & is_div_op & ~FlushE;
  assign last_iter = (state == CALC) & (count == 5'd0);

  assign a_neg    = op_signed & A[31];
  assign b_neg    = op_signed & B[31];
  assign a_mag    = a_neg ? (~A + 32'd1) : A;
  assign b_mag    = b_neg ? (~B + 32'd1) : B;
  assign div_zero = (B == 32'd0);
  assign ovf      = op_signed & (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
  assign fast     = div_zero | ovf | cache_hit;

`ifdef DIV_REM_CACHE_EN
  logic        c_valid, c_signed, s_signed;
  logic [31:0] c_a, c_b, c_quo, c_rem, s_a, s_b;

  assign cache_hit = c_valid & (A == c_a) & (B == c_b) & (op_signed == c_signed);
`else
  assign cache_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fast_result = 32'd0;
    if (div_zero)      fast_result = op_rem ? A : 32'hFFFF_FFFF;
    else if (ovf)      fast_result = op_rem ? 32'd0 : 32'h8000_0000;
`ifdef DIV_REM_CACHE_EN
    else if (cache_hit) fast_result = op_rem ? c_rem : c_quo;
`endif
  end

  // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative.
  always_comb begin
    shifted  = {rem, quo[31]};
    trial    = shifted - {2'b00, dvs};
    rem_step = shifted[32:0];
    quo_step = {quo[30:0], 1'b0};
    if (!trial[33]) begin
      rem_step = trial[32:0];
      quo_step = {quo[30:0], 1'b1};
    end
    q_fix       = s_qneg ? (~quo_step + 32'd1) : quo_step;
    r_fix       = s_rneg ? (~rem_step[31:0] + 32'd1) : rem_step[31:0];
    calc_result = s_rem ? r_fix : q_fix;
  end

  always_comb begin
    state_next = state;
    if (FlushE) state_next = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_next = fast ? DONE : CALC;
        CALC:    if (count == 5'd0) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 5'd0;
      DoneE      <= 1'b0;
      DivResultE <= 32'd0;
    end else begin
      DoneE <= 1'b0;
      if (accept) begin
        count <= 5'd31;
        if (fast) begin
          DoneE      <= 1'b1;
          DivResultE <= fast_result;
        end
      end else if (last_iter && !FlushE) begin
        DoneE      <= 1'b1;
        DivResultE <= calc_result;
      end else if (state == CALC) begin
        count <= count - 5'd1;
      end
    end
  end

  // NOTE: datapath and cache payload carry no reset; only the control bits that qualify them do.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem    <= 33'd0;
      quo    <= a_mag;
      dvs    <= b_mag;
      s_rem  <= op_rem;
      s_qneg <= a_neg ^ b_neg;
      s_rneg <= a_neg;
`ifdef DIV_REM_CACHE_EN
      s_a      <= A;
      s_b      <= B;
      s_signed <= op_signed;
`endif
    end else if (state == CALC) begin
      rem <= rem_step;
      quo <= quo_step;
    end
  end

`ifdef DIV_REM_CACHE_EN
  always_ff @(posedge clk) begin
    if (last_iter && !FlushE) begin
      c_quo    <= q_fix;
      c_rem    <= r_fix;
      c_a      <= s_a;
      c_b      <= s_b;
      c_signed <= s_signed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   c_valid <= 1'b0;
    else if (FlushE)              c_valid <= 1'b0;
    else if (last_iter)           c_valid <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus a randomized sweep
// against an arithmetic reference model that also tracks result-cache latency.
module tb_div_unit;

  localparam logic [4:0] DIV_OP  = 5'b10001;
  localparam logic [4:0] DIVU_OP = 5'b10101;
  localparam logic [4:0] REM_OP  = 5'b11001;
  localparam logic [4:0] REMU_OP = 5'b11101;
`ifdef DIV_REM_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, StartE, FlushE, StallE, DoneE;
  logic [4:0]  ALUControlE;
  logic [31:0] A, B, DivResultE;

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  logic [31:0] m_a, m_b, last_res;
  bit          m_s;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .StartE(StartE), .ALUControlE(ALUControlE),
    .A(A), .B(B), .FlushE(FlushE), .StallE(StallE), .DoneE(DoneE),
    .DivResultE(DivResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    bit s = (op == DIV_OP) || (op == REM_OP);
    bit r = (op == REM_OP) || (op == REMU_OP);
    logic signed [31:0] sa = a;
    logic signed [31:0] sb = b;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
    if (s && r) return sa % sb;
    if (s)      return sa / sb;
    if (r)      return a % b;
    return a / b;
  endfunction

  // Called at posedge+1 with the unit idle; leaves StartE low one cycle after the DONE cycle.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    int exp_lat;
    bit s, special, hit;
    logic [31:0] exp;
    s       = (op == DIV_OP) || (op == REM_OP);
    special = (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit     = CACHE_EN && m_valid && m_a == a && m_b == b && m_s == s;
    exp_lat = (special || hit) ? 1 : 33;
    exp     = ref_div(op, a, b);
    StartE = 1'b1; ALUControlE = op; A = a; B = b;
    #1 check({tag, " stall_accept"}, 32'(StallE), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!DoneE && n < 100);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, DivResultE, exp);
    check({tag, " stall_done"}, 32'(StallE), 32'd0);
    if (!special) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_s = s;
    end
    last_res = exp;
    @(posedge clk); #1;
    StartE = 1'b0;
    check({tag, " done_pulse"}, 32'(DoneE), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ops [4] = '{DIV_OP, DIVU_OP, REM_OP, REMU_OP};
    logic [31:0] ra, rb;
    int dones;

    rst_n = 1'b0; StartE = 1'b0; FlushE = 1'b0; ALUControlE = 5'd0; A = 32'd0; B = 32'd0;
    m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_s = 1'b0; last_res = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset DoneE", 32'(DoneE), 32'd0);
    check("reset DivResultE", DivResultE, 32'd0);
    check("reset StallE", 32'(StallE), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(DIVU_OP, 32'd100, 32'd7, "divu100_7");
    run_op(REMU_OP, 32'd100, 32'd7, "remu100_7");
    run_op(DIV_OP, 32'hFFFF_FFF9, 32'd2, "div-7_2");
    run_op(REM_OP, 32'hFFFF_FFF9, 32'd2, "rem-7_2");
    run_op(DIV_OP, 32'd5, 32'd0, "div5_0");
    run_op(REMU_OP, 32'd5, 32'd0, "remu5_0");
    run_op(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    StartE = 1'b1; ALUControlE = 5'b00000; A = 32'd9; B = 32'd3;
    #1 check("nondiv stall", 32'(StallE), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("nondiv done", 32'(DoneE), 32'd0);
    StartE = 1'b0;

    // Flush during the tenth iteration.
    StartE = 1'b1; ALUControlE = DIVU_OP; A = 32'd1000; B = 32'd3;
    repeat (10) @(posedge clk);
    #1 StartE = 1'b0; FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0; m_valid = 1'b0;
    check("flush stall", 32'(StallE), 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (DoneE) dones++;
    end
    check("flush no_done", 32'(dones), 32'd0);
    check("flush result_kept", DivResultE, last_res);
    run_op(DIVU_OP, 32'd1000, 32'd3, "after_flush");

    // Reset in the middle of an iteration.
    StartE = 1'b1; ALUControlE = DIV_OP; A = 32'd12345; B = 32'd17;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midreset DoneE", 32'(DoneE), 32'd0);
    check("midreset DivResultE", DivResultE, 32'd0);
    StartE = 1'b0; m_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(DIVU_OP, 32'd100, 32'd7, "b2b_divu");
    run_op(REMU_OP, 32'd100, 32'd7, "b2b_remu");

    for (int i = 0; i < 1500; i++) begin
      if (i == 0 || $urandom_range(0, 3) != 0) begin
        ra = pick();
        rb = pick();
      end
      run_op(ops[$urandom_range(0, 3)], ra, rb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
